// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes and protection default.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_if.sv
// Shared AXI-lite interface with initiator and target views.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mem_axi_master.sv
// Single-outstanding core-request to AXI-lite initiator bridge with
// per-transaction timeout.
module mem_axi_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  axi_lite_if.master              m_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                expire;

  // The incremented count includes the current busy cycle.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign expire  = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT - 1));

  // Gated with rst_n so no request is taken while reset is held.
  assign req_ready  = rst_n && (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign m_axi.arvalid = (state_q == RADDR);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = PROT_DEFAULT;
  assign m_axi.rready  = (state_q == RDATA);
  assign m_axi.awvalid = (state_q == WREQ) && !aw_done_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = PROT_DEFAULT;
  assign m_axi.wvalid  = (state_q == WREQ) && !w_done_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = (state_q == WRESP);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          state_d   = req_we ? WREQ : RADDR;
        end
      end
      RADDR: begin
        cnt_d = cnt_inc;
        if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (m_axi.arready) begin
          state_d = RDATA;
        end
      end
      // A beat consumed on the expiry cycle is reported rather than dropped.
      RDATA: begin
        cnt_d = cnt_inc;
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          err_d   = (m_axi.rresp != RESP_OKAY);
          state_d = DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WREQ: begin
        cnt_d = cnt_inc;
        if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          if (m_axi.awready) aw_done_d = 1'b1;
          if (m_axi.wready)  w_done_d  = 1'b1;
          if (aw_done_d && w_done_d) state_d = WRESP;
        end
      end
      WRESP: begin
        cnt_d = cnt_inc;
        if (m_axi.bvalid) begin
          err_d   = (m_axi.bresp != RESP_OKAY);
          state_d = DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_axi_master.sv
// Scoreboard bench for mem_axi_master against a 4096-word RAM slave model
// whose RAM access takes one cycle between address capture and response.
module tb_mem_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  mem_axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .m_axi      (axi)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [0:4095];
  logic        ar_block, bresp_err;
  int          aw_delay, aw_wait, b_count;
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;
  logic        r_stage, aw_have, w_have;
  logic [11:0] r_idx, aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  assign axi.arready = !ar_block;
  assign axi.awready = (aw_wait >= aw_delay);
  assign axi.wready  = 1'b1;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (axi.bvalid && axi.bready) b_count <= b_count + 1;
    if (!rst_n) begin
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= 2'b00;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      r_stage    <= 1'b0;
      aw_have    <= 1'b0;
      w_have     <= 1'b0;
      aw_wait    <= 0;
    end else begin
      if (axi.arvalid && axi.arready) begin
        r_stage <= 1'b1;
        r_idx   <= axi.araddr[13:2];
      end
      if (r_stage) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= mem[r_idx];
        axi.rresp  <= 2'b00;
        r_stage    <= 1'b0;
      end else if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
      end
      if (axi.awvalid && axi.awready) begin
        aw_have <= 1'b1;
        aw_idx  <= axi.awaddr[13:2];
        aw_wait <= 0;
      end else if (axi.awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (axi.wvalid && axi.wready) begin
        w_have <= 1'b1;
        w_data <= axi.wdata;
        w_strb <= axi.wstrb;
      end
      if (aw_have && w_have) begin
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        axi.bvalid <= 1'b1;
        axi.bresp  <= bresp_err ? 2'b10 : 2'b00;
        aw_have    <= 1'b0;
        w_have     <= 1'b0;
      end else if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_valid=1 with rdata 0x%0h, expected none", resp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_err"}, resp_err, e.err);
        check({e.name, "_lat"}, cyc - e.acc, e.lat);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input logic [11:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input string name);
    logic accepted;
    exp_t e;
    accepted = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        e.name = name; e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_accepted"}, accepted, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({name, "_completed"}, sb.size() == 0, 1'b1);
    sb.delete();
  endtask

  int b_before;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    ar_block = 1'b0; bresp_err = 1'b0; aw_delay = 0; b_count = 0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;

    preload(12'd4, 32'hDEADBEEF);   // 0x80000010
    preload(12'd8, 32'hAAAAAAAA);   // 0x80000020
    @(negedge clk);
    check("rst_req_ready",  req_ready,  1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp",       {resp_err, resp_rdata}, 33'h0);
    check("rst_valids",     {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    check("rst_addr",       {axi.araddr, axi.wdata}, 64'h0);
    check("rst_prot",       {axi.arprot, axi.awprot}, 6'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 4, "rd_basic");
    wait_done("rd_basic");

    issue(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 4, "wr_strb");
    wait_done("wr_strb");
    issue(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'hAAAA5678, 1'b0, 4, "rd_strb");
    wait_done("rd_strb");

    aw_delay = 3;
    b_before = b_count;
    issue(1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 7, "wr_awslow");
    @(negedge clk);
    check("awslow_c1_valids", {axi.awvalid, axi.wvalid}, 2'b11);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("awslow_c%0d_valids", k), {axi.awvalid, axi.wvalid}, 2'b10);
      check($sformatf("awslow_c%0d_awaddr", k), axi.awaddr, 32'h8000_0030);
    end
    wait_done("wr_awslow");
    check("awslow_b_count", b_count - b_before, 1);
    aw_delay = 0;
    issue(1'b0, 32'h8000_0030, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 4, "rd_awslow");
    wait_done("rd_awslow");

    bresp_err = 1'b1;
    issue(1'b1, 32'h8000_0040, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 4, "wr_slverr");
    wait_done("wr_slverr");
    bresp_err = 1'b0;
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 4, "rd_after_err");
    wait_done("rd_after_err");

    ar_block = 1'b1;
    issue(1'b0, 32'h8000_0050, 32'h0, 4'h0, 32'h0, 1'b1, 16, "rd_timeout");
    wait_done("rd_timeout");
    repeat (3) begin
      @(negedge clk);
      check("timeout_arvalid_low", axi.arvalid, 1'b0);
    end
    ar_block = 1'b0;

    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 4, "rd_reset");
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_valids", {resp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 6'b0);
    repeat (6) @(negedge clk);
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 4, "rd_post_reset");
    wait_done("rd_post_reset");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
